vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; the next generation of the team's fixed 640x480@60 controller.
- Every timing interval and sync polarity is a parameter; counters wrap at exactly the total period.
- Adds a pixel-rate clock enable, line/frame start strobes, an active-video flag and a frame counter.
- Sits between the pixel clock domain and the pixel/colour generator; all outputs are registered and mutually aligned.

---
 rtl/vga_timing_gen.sv | 184 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Every porch/sync interval and both sync polarities are parameters, and the
// counters wrap at exactly the total period. All outputs are registered and
// describe the same pixel: they show the decode of (h_cnt, v_cnt) one enabled
// cycle behind the counters. 'enable' acts as a pixel-rate clock enable.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the completed-frame
// counter; when it is undefined, frame_count is tied to zero.

module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 11,
    parameter int   FCW      = 8
) (
    input  logic           pixel_clk,
    input  logic           rst,
    input  logic           enable,
    output logic           HS,
    output logic           VS,
    output logic           blank,
    output logic           active,
    output logic [CW-1:0]  hcounter,
    output logic [CW-1:0]  vcounter,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync end bounds never overflow CW because each back porch is at least 1.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    logic          active_q, active_d;
    logic [CW-1:0] hcnt_out_q, hcnt_out_d;
    logic [CW-1:0] vcnt_out_q, vcnt_out_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          at_line_origin;
    logic          at_frame_origin;
    logic          in_hsync;
    logic          in_vsync;
    logic          in_blank;

    // Raster position decode of the current counter values.
    always_comb begin
        at_line_origin  = (h_cnt_q == '0);
        at_frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        in_hsync        = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
        in_vsync        = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
        in_blank        = (h_cnt_q >= H_ACT_END) || (v_cnt_q >= V_ACT_END);
    end

    // Counter advance: h wraps at H_TOTAL-1 and carries into v, which wraps at V_TOTAL-1.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (enable) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + CW'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + CW'(1);
            end
        end
    end

    // Output loads: enabled cycles present the current pixel; stalled cycles hold and drop strobes.
    always_comb begin
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_d       = blank_q;
        active_d      = active_q;
        hcnt_out_d    = hcnt_out_q;
        vcnt_out_d    = vcnt_out_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            hs_d          = in_hsync ? HS_POL : ~HS_POL;
            vs_d          = in_vsync ? VS_POL : ~VS_POL;
            blank_d       = in_blank;
            active_d      = ~in_blank;
            hcnt_out_d    = h_cnt_q;
            vcnt_out_d    = v_cnt_q;
            line_start_d  = at_line_origin;
            frame_start_d = at_frame_origin;
        end
    end

    // State and output registers with synchronous reset back to the idle raster.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            blank_q       <= 1'b1;
            active_q      <= 1'b0;
            hcnt_out_q    <= '0;
            vcnt_out_q    <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            active_q      <= active_d;
            hcnt_out_q    <= hcnt_out_d;
            vcnt_out_q    <= vcnt_out_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           seen_first_q, seen_first_d;

    // Count frame starts, but let the first one after reset mark frame 0 instead of incrementing.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        seen_first_d = seen_first_q;
        if (enable && at_frame_origin) begin
            seen_first_d = 1'b1;
            if (seen_first_q) begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    // Frame counter registers.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            frame_cnt_q  <= '0;
            seen_first_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            seen_first_q <= seen_first_d;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = '0;
`endif

    assign HS          = hs_q;
    assign VS          = vs_q;
    assign blank       = blank_q;
    assign active      = active_q;
    assign hcounter    = hcnt_out_q;
    assign vcounter    = vcnt_out_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (a) and a tiny
// 7x5 instance with positive syncs and a 2-bit frame counter (b), both checked
// every cycle against a pixel-index raster model plus hand-computed pins.
`timescale 1ns/1ps

module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a: default parameters
    logic        a_rst, a_en;
    logic        a_hs, a_vs, a_bl, a_ac, a_ls, a_fs;
    logic [10:0] a_hc, a_vc;
    logic [7:0]  a_fc;

    // instance b: H 4/1/1/1, V 2/1/1/1, positive syncs, FCW=2
    logic        b_rst, b_en;
    logic        b_hs, b_vs, b_bl, b_ac, b_ls, b_fs;
    logic [3:0]  b_hc, b_vc;
    logic [1:0]  b_fc;

    vga_timing_gen dut_a (
        .pixel_clk(clk), .rst(a_rst), .enable(a_en),
        .HS(a_hs), .VS(a_vs), .blank(a_bl), .active(a_ac),
        .hcounter(a_hc), .vcounter(a_vc),
        .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FCW(2)
    ) dut_b (
        .pixel_clk(clk), .rst(b_rst), .enable(b_en),
        .HS(b_hs), .VS(b_vs), .blank(b_bl), .active(b_ac),
        .hcounter(b_hc), .vcounter(b_vc),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    localparam int P_HA[2]  = '{640, 4};
    localparam int P_HF[2]  = '{16, 1};
    localparam int P_HS[2]  = '{96, 1};
    localparam int P_HB[2]  = '{48, 1};
    localparam int P_VA[2]  = '{480, 2};
    localparam int P_VF[2]  = '{10, 1};
    localparam int P_VS[2]  = '{2, 1};
    localparam int P_VB[2]  = '{33, 1};
    localparam bit P_HP[2]  = '{1'b0, 1'b1};
    localparam bit P_VP[2]  = '{1'b0, 1'b1};
    localparam int P_FCW[2] = '{8, 2};

    int checks   = 0;
    int failures = 0;
    bit done_a   = 1'b0;
    bit done_b   = 1'b0;

    // model: position = pixel index within the frame
    int   m_pos[2];
    int   m_fseen[2];
    logic e_hs[2], e_vs[2], e_bl[2], e_ls[2], e_fs[2];
    int   e_hc[2], e_vc[2], e_fc[2];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic model_step(input int id, input logic r, input logic en);
        int ht, vt, h, v;
        ht = P_HA[id] + P_HF[id] + P_HS[id] + P_HB[id];
        vt = P_VA[id] + P_VF[id] + P_VS[id] + P_VB[id];
        if (r) begin
            m_pos[id] = 0; m_fseen[id] = 0;
            e_hs[id] = ~P_HP[id]; e_vs[id] = ~P_VP[id]; e_bl[id] = 1'b1;
            e_hc[id] = 0; e_vc[id] = 0; e_ls[id] = 1'b0; e_fs[id] = 1'b0; e_fc[id] = 0;
        end else if (en) begin
            h = m_pos[id] % ht;
            v = m_pos[id] / ht;
            e_hc[id] = h;
            e_vc[id] = v;
            e_hs[id] = (h >= P_HA[id] + P_HF[id] && h < P_HA[id] + P_HF[id] + P_HS[id]) ? P_HP[id] : ~P_HP[id];
            e_vs[id] = (v >= P_VA[id] + P_VF[id] && v < P_VA[id] + P_VF[id] + P_VS[id]) ? P_VP[id] : ~P_VP[id];
            e_bl[id] = (h >= P_HA[id]) || (v >= P_VA[id]);
            e_ls[id] = (h == 0);
            e_fs[id] = (m_pos[id] == 0);
            if (m_pos[id] == 0) m_fseen[id]++;
`ifdef VGA_TIMING_FRAME_CNT_EN
            e_fc[id] = (m_fseen[id] == 0) ? 0 : (m_fseen[id] - 1) % (1 << P_FCW[id]);
`else
            e_fc[id] = 0;
`endif
            m_pos[id] = (m_pos[id] + 1) % (ht * vt);
        end else begin
            e_ls[id] = 1'b0;
            e_fs[id] = 1'b0;
        end
    endtask

    task automatic cmp(input int id, input string p, input logic hs, input logic vs, input logic bl,
                       input logic ac, input logic [31:0] hc, input logic [31:0] vc,
                       input logic ls, input logic fs, input logic [31:0] fc);
        chk({p, "HS"}, hs, e_hs[id]);
        chk({p, "VS"}, vs, e_vs[id]);
        chk({p, "blank"}, bl, e_bl[id]);
        chk({p, "active"}, ac, !e_bl[id]);
        chk({p, "hcounter"}, hc, e_hc[id]);
        chk({p, "vcounter"}, vc, e_vc[id]);
        chk({p, "line_start"}, ls, e_ls[id]);
        chk({p, "frame_start"}, fs, e_fs[id]);
        chk({p, "frame_count"}, fc, e_fc[id]);
    endtask

    // compare process: advance the model on each edge, check both DUTs mid-cycle
    initial begin
        forever begin
            @(posedge clk);
            model_step(0, a_rst, a_en);
            model_step(1, b_rst, b_en);
            @(negedge clk);
            cmp(0, "a_", a_hs, a_vs, a_bl, a_ac, 32'(a_hc), 32'(a_vc), a_ls, a_fs, 32'(a_fc));
            cmp(1, "b_", b_hs, b_vs, b_bl, b_ac, 32'(b_hc), 32'(b_vc), b_ls, b_fs, 32'(b_fc));
        end
    end

    // instance a: reset, two full lines, stalled line, random stress
    initial begin
        int ls_n, last_ls, hs_low, hs_bad, bl0, bl_bad, hc_max;
        logic prev_ls;
        a_rst = 1'b1; a_en = 1'b1;
        repeat (3) tick;
        chk("a_rst_HS", a_hs, 1); chk("a_rst_VS", a_vs, 1); chk("a_rst_blank", a_bl, 1);
        chk("a_rst_hc", 32'(a_hc), 0); chk("a_rst_vc", 32'(a_vc), 0);
        chk("a_rst_ls", a_ls, 0); chk("a_rst_fs", a_fs, 0);
        a_rst = 1'b0;
        ls_n = 0; last_ls = -1; hs_low = 0; hs_bad = 0; bl0 = 0; bl_bad = 0; hc_max = 0;
        for (int i = 0; i < 1600; i++) begin
            tick;
            if (i == 0) begin
                chk("a_first_hc", 32'(a_hc), 0); chk("a_first_vc", 32'(a_vc), 0);
                chk("a_first_blank", a_bl, 0); chk("a_first_ls", a_ls, 1); chk("a_first_fs", a_fs, 1);
            end
            if (a_ls) begin
                ls_n++;
                if (last_ls >= 0) chk("a_line_period", last_ls + 800, i);
                last_ls = i;
            end
            if (!a_hs) begin
                hs_low++;
                if (a_hc < 656 || a_hc > 751) hs_bad++;
            end
            if (!a_bl) begin
                bl0++;
                if (a_hc > 639) bl_bad++;
            end
            if (int'(a_hc) > hc_max) hc_max = int'(a_hc);
        end
        chk("a_ls_count", ls_n, 2);
        chk("a_hs_low_cycles", hs_low, 192);
        chk("a_hs_low_outside_656_751", hs_bad, 0);
        chk("a_visible_cycles", bl0, 1280);
        chk("a_visible_beyond_639", bl_bad, 0);
        chk("a_hc_max", hc_max, 799);

        ls_n = 0; last_ls = -1; prev_ls = a_ls;
        for (int i = 0; i < 3200; i++) begin
            a_en = (i % 2 == 0);
            tick;
            if (a_ls) begin
                ls_n++;
                chk("a_stall_ls_single", prev_ls, 0);
                if (last_ls >= 0) chk("a_stall_line_period", i - last_ls, 1600);
                last_ls = i;
            end
            prev_ls = a_ls;
        end
        chk("a_stall_ls_count", ls_n, 2);

        for (int i = 0; i < 6000; i++) begin
            a_en  = ($urandom_range(0, 3) != 0);
            a_rst = ($urandom_range(0, 999) == 0);
            tick;
        end
        done_a = 1'b1;
    end

    // instance b: frame timing, frame counter wrap, mid-frame reset, random stress
    initial begin
        int fc_seen[$];
        int fc_exp[6];
        int last_fs, last_ls, hs_n, hs_bad, vs_n, vs_bad;
        bit found;
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc_exp = '{0, 1, 2, 3, 0, 1};
`else
        fc_exp = '{0, 0, 0, 0, 0, 0};
`endif
        b_rst = 1'b1; b_en = 1'b1;
        repeat (3) tick;
        chk("b_rst_HS", b_hs, 0); chk("b_rst_VS", b_vs, 0); chk("b_rst_blank", b_bl, 1);
        b_rst = 1'b0;
        last_fs = -1; last_ls = -1; hs_n = 0; hs_bad = 0; vs_n = 0; vs_bad = 0;
        for (int i = 0; i < 210; i++) begin
            tick;
            if (b_fs) begin
                fc_seen.push_back(int'(b_fc));
                if (last_fs >= 0) chk("b_frame_period", i - last_fs, 35);
                last_fs = i;
            end
            if (b_ls) begin
                if (last_ls >= 0) chk("b_line_period", i - last_ls, 7);
                last_ls = i;
            end
            if (b_hs) begin hs_n++; if (b_hc != 5) hs_bad++; end
            if (b_vs) begin vs_n++; if (b_vc != 3) vs_bad++; end
        end
        chk("b_hs_cycles", hs_n, 30);
        chk("b_hs_not_h5", hs_bad, 0);
        chk("b_vs_cycles", vs_n, 42);
        chk("b_vs_not_v3", vs_bad, 0);
        chk("b_frame_starts", fc_seen.size(), 6);
        for (int k = 0; k < 6 && k < fc_seen.size(); k++) chk($sformatf("b_fc_seq%0d", k), fc_seen[k], fc_exp[k]);

        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (b_vc == 3 && b_hc == 5) found = 1'b1;
            else tick;
        end
        chk("b_reach_v3h5", found, 1);
        if (found) begin
            chk("b_v3h5_HS", b_hs, 1); chk("b_v3h5_VS", b_vs, 1);
            b_rst = 1'b1;
            tick;
            chk("b_mid_rst_HS", b_hs, 0); chk("b_mid_rst_VS", b_vs, 0); chk("b_mid_rst_blank", b_bl, 1);
            chk("b_mid_rst_hc", 32'(b_hc), 0); chk("b_mid_rst_vc", 32'(b_vc), 0);
            chk("b_mid_rst_fc", 32'(b_fc), 0);
            b_rst = 1'b0;
            tick;
            chk("b_after_rst_fs", b_fs, 1); chk("b_after_rst_fc", 32'(b_fc), 0);
            chk("b_after_rst_HS", b_hs, 0);
        end

        for (int i = 0; i < 4000; i++) begin
            b_en  = ($urandom_range(0, 2) != 0);
            b_rst = ($urandom_range(0, 199) == 0);
            tick;
        end
        done_b = 1'b1;
    end

    initial begin
        wait (done_a && done_b);
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
